calc_arbiter: RTL
=================

# calc_arbiter

Shares one sequenced compute datapath (the controller plus its A/B/answer datapath) among N_REQ requesters. The block picks one pending requester round-robin, forwards its operands, pulses the datapath start, waits for datapath done, then returns the result to the winner with a one-cycle ack. It sits between the requesting units and the datapath controller's `start`/done pair.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DW, 8, operand width
- RW, 16, result width
- TIMEOUT, 64, WAIT-state cycle limit (used only with watchdog compiled in)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester request level; held until own ack
- op_a  in  N_REQ*DW  packed operand A; requester i at bits [i*DW +: DW]
- op_b  in  N_REQ*DW  packed operand B, same packing
- gnt  out  N_REQ  one-hot grant, held from ISSUE through RESP
- ack  out  N_REQ  one-hot, one-cycle pulse in RESP
- result  out  RW  registered result; valid while ack is high, held afterwards
- err  out  1  high with ack when the transaction timed out
- dp_start  out  1  one-cycle start pulse to the datapath controller
- dp_a, dp_b  out  DW  registered operands to the datapath
- dp_done  in  1  datapath completion; dp_result valid in the same cycle
- dp_result  in  RW  datapath result

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, pick a winner g and go to ISSUE. Register gnt = onehot(g), dp_a = op_a[g], and dp_b = op_b[g]. Operands are sampled once; later op changes are ignored.
- ISSUE: dp_start = 1 for exactly this cycle. Next state is WAIT.
- WAIT: dp_start = 0. When dp_done = 1, latch result = dp_result and go to RESP. dp_done is ignored in every other state.
- RESP: ack[g] = 1 and err is valid. Next state is IDLE. gnt clears on entering IDLE.
- Round-robin: a pointer ptr (log2 N_REQ bits) is the highest-priority index. The winner is the first set req at or after ptr, with modular wrap. In RESP, ptr becomes (g+1) mod N_REQ; when g = N_REQ-1, ptr wraps to 0.
- If req[g] drops mid-transaction, the transaction still completes and ack[g] still pulses. The requester discards it.
- If req[g] is still high after its ack, it is re-arbitrated normally. Round-robin guarantees that other pending requesters are served first.
- Reset (rst = 0, any state, including mid-WAIT):
  - state = IDLE, ptr = 0
  - gnt = 0, ack = 0, err = 0, dp_start = 0
  - dp_a = 0, dp_b = 0, result = 0
  - The in-flight transaction is abandoned; no ack is issued for it.

## Timing
- Arbitration decision in IDLE takes 1 cycle. dp_start is high in cycle +1 after the edge where req was sampled.
- dp_done sampled in cycle k causes ack in cycle k+1.
- Minimum turnaround is 3 cycles plus datapath latency. Back-to-back grants have one IDLE cycle between RESP and the next ISSUE.
- dp_done arriving in the same cycle WAIT is entered is accepted.
- All outputs are registered; none depends combinationally on req or dp_done.

## Configuration
- `CALC_ARB_WATCHDOG_EN` defined:
  - A cycle counter is cleared in ISSUE and increments in WAIT.
  - If it reaches TIMEOUT with no dp_done, go to RESP with result = 0 and err = 1.
  - ptr advances as normal.
  - A dp_done arriving after the timeout is ignored, because it falls outside WAIT.
- Not defined:
  - No counter is built; WAIT lasts until dp_done.
  - err is tied to 0.
  - The port list is identical in both builds.

## Structure
- Shared package calc_arb_pkg holds:
  - the FSM state enum (IDLE, ISSUE, WAIT, RESP, 2-bit encoding)
  - default DW/RW/N_REQ constants
  - the TIMEOUT counter width function
- One sub-module, rr_picker: combinational. Takes req and ptr; returns a one-hot winner and its index.
- The FSM, pointer, and operand/result registers live in calc_arbiter.

## Test plan
- Single request: req = 0001, op_a[0] = 5, op_b[0] = 3, datapath model responds with done 4 cycles after start and result 15.
  - Expect gnt = 0001, one dp_start pulse with dp_a = 5 and dp_b = 3.
  - Expect ack = 0001 with result = 15 and err = 0.
- Simultaneous: req = 1111 held from reset release. Expect grant order 0, 1, 2, 3, 0 (ptr wrap) and exactly one ack per grant.
- Fairness: req = 0110 with ptr = 2 after a prior grant to 1. Expect the grant to go to 2, then 1.
- Requester drop: req[1] is deasserted during WAIT. Expect the transaction to complete, ack[1] to pulse once, and no re-grant to 1.
- Reset mid-WAIT: assert rst = 0 in WAIT.
  - Expect all outputs 0 immediately (asynchronous) and no ack after release.
  - Expect the next grant to follow from ptr = 0.
- Watchdog (macro on, TIMEOUT = 8): hold dp_done low. Expect ack with err = 1 and result = 0 eight WAIT cycles after ISSUE. With the macro off, the same stimulus leaves the FSM in WAIT indefinitely and err stays 0.

Source files
------------

// File: rtl/calc_arb_pkg.sv
// Shared types and defaults for the calc_arbiter slice.
// Holds the FSM encoding, default widths and the watchdog counter sizing helper.
package calc_arb_pkg;
    localparam int N_REQ_DEF   = 4;
    localparam int DW_DEF      = 8;
    localparam int RW_DEF      = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // The WAIT counter only has to hold 0..timeout-1 before the timeout fires.
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction
endpackage

// File: rtl/calc_arbiter_if.sv
// Requester and datapath signals of calc_arbiter bundled as one interface.
// slave is the arbiter's view; master is the requesters-plus-datapath view.
// Latency/backpressure: none here, wiring only.
interface calc_arbiter_if
    import calc_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int RW    = RW_DEF
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] op_a;
    logic [N_REQ*DW-1:0] op_b;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    ack;
    logic [RW-1:0]       result;
    logic                err;
    logic                dp_start;
    logic [DW-1:0]       dp_a;
    logic [DW-1:0]       dp_b;
    logic                dp_done;
    logic [RW-1:0]       dp_result;

    modport slave (
        input  req, op_a, op_b, dp_done, dp_result,
        output gnt, ack, result, err, dp_start, dp_a, dp_b
    );

    modport master (
        output req, op_a, op_b, dp_done, dp_result,
        input  gnt, ack, result, err, dp_start, dp_a, dp_b
    );
endinterface

// File: rtl/calc_arbiter_rr_picker.sv
// Round-robin winner select: first set req at or after ptr, wrapping modulo N_REQ.
// Latency: combinational.
// Backpressure: none, pure function of req and ptr.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [PW-1:0]    win_idx,
    output logic             win_vld
);
    int j;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!win_vld && req[j]) begin
                win_vld   = 1'b1;
                win_oh[j] = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end
endmodule

// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one start/done compute datapath among N_REQ requesters.
// Latency: req sampled -> dp_start next cycle; dp_done -> ack next cycle; one IDLE cycle between grants.
// Backpressure: req held until ack; WAIT holds until dp_done, or TIMEOUT cycles with CALC_ARB_WATCHDOG_EN.
module calc_arbiter
    import calc_arb_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic           clk,
    input logic           rst_n,
    calc_arbiter_if.slave bus
);
    localparam int PW = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             dp_start_q, dp_start_d;
    logic [DW-1:0]    dp_a_q, dp_a_d;
    logic [DW-1:0]    dp_b_q, dp_b_d;
    logic [RW-1:0]    result_q, result_d;
    logic [PW-1:0]    ptr_after;

    logic [N_REQ-1:0] win_oh;
    logic [PW-1:0]    win_idx;
    logic             win_vld;

    rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    assign ptr_after = (gidx_q == PW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

`ifdef CALC_ARB_WATCHDOG_EN
    localparam int CW = cnt_width(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        dp_start_d = 1'b0;
        dp_a_d     = dp_a_q;
        dp_b_d     = dp_b_q;
        result_d   = result_q;
`ifdef CALC_ARB_WATCHDOG_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d    = ST_ISSUE;
                    gidx_d     = win_idx;
                    gnt_d      = win_oh;
                    dp_a_d     = bus.op_a[int'(win_idx)*DW +: DW];
                    dp_b_d     = bus.op_b[int'(win_idx)*DW +: DW];
                    dp_start_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef CALC_ARB_WATCHDOG_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (bus.dp_done) begin
                    state_d  = ST_RESP;
                    result_d = bus.dp_result;
                    ack_d    = gnt_q;
                end
`ifdef CALC_ARB_WATCHDOG_EN
                // Last WAIT cycle with count TIMEOUT-1 means TIMEOUT cycles have elapsed.
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = ST_RESP;
                    result_d = '0;
                    err_d    = 1'b1;
                    ack_d    = gnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                ptr_d   = ptr_after;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            dp_start_q <= 1'b0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            dp_start_q <= dp_start_d;
            dp_a_q     <= dp_a_d;
            dp_b_q     <= dp_b_d;
            result_q   <= result_d;
        end
    end

`ifdef CALC_ARB_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.result   = result_q;
    assign bus.dp_start = dp_start_q;
    assign bus.dp_a     = dp_a_q;
    assign bus.dp_b     = dp_b_q;
endmodule
